noise_shaper_stream: RTL



---
 rtl/noise_shaper_stream.sv | 121 ++++++++++++
 1 files changed

// File: rtl/noise_shaper_stream.sv
// Central-limit noise shaper: sums uniform 16-bit LFSR slices, normalises,
// applies a Q0.16 gain and streams the result over AXI4-Stream with drop counting.
module noise_shaper_stream #(
  parameter int N_SUM_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rnd_in,
  input  logic        enable,
  input  logic [15:0] gain,
  input  logic        clear_drops,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] drop_count
);

  localparam int ACC_WIDTH = 17 + N_SUM_LOG2;
  localparam logic [N_SUM_LOG2-1:0] CNT_LAST = '1;

  logic signed [16:0]          pair_q, pair_d;
  logic                        pair_v_q, pair_v_d;
  logic [N_SUM_LOG2-1:0]       cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                        sum_v_q, sum_v_d;
  logic signed [15:0]          prod_q, prod_d;
  logic                        prod_v_q, prod_v_d;
  logic [15:0]                 tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic [31:0]                 drop_q, drop_d;

  logic signed [ACC_WIDTH-1:0] pair_ext;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [15:0]          scaled;
  logic signed [32:0]          prod;
  logic                        load;
  logic                        drop;

  always_comb begin
    pair_d   = pair_q;
    pair_v_d = enable;
    if (enable) begin
      pair_d = 17'($signed(rnd_in[15:0])) + 17'($signed(rnd_in[31:16]));
    end

    // Frames only advance on valid pairs, so enable gaps pause rather than restart a frame.
    pair_ext = ACC_WIDTH'(pair_q);
    acc_sum  = acc_q + pair_ext;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    sum_v_d  = pair_v_q && (cnt_q == CNT_LAST);
    if (pair_v_q) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = (cnt_q == '0) ? pair_ext : acc_sum;
      if (cnt_q == CNT_LAST) begin
        sum_d = acc_sum;
      end
    end

    // Dividing by the slice count keeps the normalised sum inside 16 bits.
    scaled   = 16'(sum_q >>> (N_SUM_LOG2 + 1));
    prod     = 33'(scaled) * 33'($signed({1'b0, gain}));
    prod_v_d = sum_v_q;
    prod_d   = prod_q;
    if (sum_v_q) begin
      prod_d = 16'(prod >>> 16);
    end

    load     = prod_v_q && (!tvalid_q || m_axis_tready);
    drop     = prod_v_q && tvalid_q && !m_axis_tready;
    tdata_d  = load ? prod_q : tdata_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tvalid_d = 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    drop_d = drop_q;
    if (clear_drops) begin
      drop_d = '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_q   <= '0;
      pair_v_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      sum_v_q  <= 1'b0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      pair_q   <= pair_d;
      pair_v_q <= pair_v_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      sum_v_q  <= sum_v_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      drop_q   <= drop_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign drop_count    = drop_q;

endmodule
